// File: rtl/sync_handshake_src_if.sv
// Bundle of the per-channel handshake and data signals of the REQ/ACK source.
// The master side is the source block itself; the slave side is whoever drives
// SEND_EN/D_IN and plays the peer returning ACK.
interface sync_handshake_src_if #(
    parameter int P_D_BITWIDTH = 8,
    parameter int P_CH         = 4
);
    logic [P_CH-1:0]              send_en;
    logic [P_CH*P_D_BITWIDTH-1:0] d_in;
    logic [P_CH*P_D_BITWIDTH-1:0] d_out;
    logic [P_CH-1:0]              req;
    logic [P_CH-1:0]              ack;
    logic [P_CH-1:0]              busy;
    logic [P_CH-1:0]              done;
    logic [P_CH-1:0]              drop;
    logic [P_CH-1:0]              err;
    logic [P_CH-1:0]              clr_err;

    modport master (
        input  send_en, d_in, ack, clr_err,
        output d_out, req, busy, done, drop, err
    );

    modport slave (
        output send_en, d_in, ack, clr_err,
        input  d_out, req, busy, done, drop, err
    );
endinterface

// File: rtl/sync_handshake_src.sv
// Multi-channel source side of a REQ/ACK clock-domain-crossing handshake.
// Each channel latches a data word on a SEND_EN rising edge, raises (4-phase)
// or toggles (2-phase) REQ, and waits for the peer's ACK after it has passed a
// FF_DEPTH-deep synchroniser. An optional watchdog parks a stuck channel in
// ERROR until software clears it and the peer has gone quiet.
module sync_handshake_src #(
    parameter int P_D_BITWIDTH = 8,
    parameter int P_CH         = 4,
    parameter int FF_DEPTH     = 2,
    parameter bit P_PHASE4     = 1'b1,
    parameter int P_TIMEOUT    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    sync_handshake_src_if.master bus
);

    // A zero-width counter is not legal, so the disabled watchdog keeps one bit.
    localparam int CNT_W = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(P_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_REL = 2'd2,
        ERROR    = 2'd3
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < P_CH; gi++) begin : g_ch
            state_t                  state_reg, state_next;
            logic                    req_reg, req_next;
            logic [P_D_BITWIDTH-1:0] dout_reg, dout_next;
            logic                    done_reg, done_next;
            logic                    drop_reg, drop_next;
            logic                    err_reg, err_next;
            logic                    busy_reg;
            logic                    send_en_d_reg;
            logic [CNT_W-1:0]        cnt_reg, cnt_next;
            (* ASYNC_REG = "TRUE" *)
            logic [FF_DEPTH-1:0]     sync_reg;

            logic                    rise;
            logic                    ack_s;
            logic [CNT_W-1:0]        cnt_inc;
            logic                    timeout_hit;
            logic                    quiet;

            assign rise        = bus.send_en[gi] & ~send_en_d_reg;
            assign ack_s       = sync_reg[FF_DEPTH-1];
            assign cnt_inc     = cnt_reg + CNT_W'(1);
            assign timeout_hit = (P_TIMEOUT > 0) && (cnt_inc == TO_LIMIT);
            // Peer is idle: ACK returned to zero (4-phase) or matches REQ (2-phase).
            assign quiet       = P_PHASE4 ? ~ack_s : (ack_s == req_reg);

            // Channel state, outputs, edge detector and ACK synchroniser.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg     <= IDLE;
                    req_reg       <= 1'b0;
                    dout_reg      <= '0;
                    done_reg      <= 1'b0;
                    drop_reg      <= 1'b0;
                    err_reg       <= 1'b0;
                    busy_reg      <= 1'b0;
                    send_en_d_reg <= 1'b0;
                    cnt_reg       <= '0;
                    sync_reg      <= '0;
                end else begin
                    state_reg     <= state_next;
                    req_reg       <= req_next;
                    dout_reg      <= dout_next;
                    done_reg      <= done_next;
                    drop_reg      <= drop_next;
                    err_reg       <= err_next;
                    busy_reg      <= (state_next != IDLE);
                    send_en_d_reg <= bus.send_en[gi];
                    cnt_reg       <= cnt_next;
                    sync_reg      <= {sync_reg[FF_DEPTH-2:0], bus.ack[gi]};
                end
            end

            // Next-state and output decode; completion is tested before the watchdog.
            always_comb begin
                state_next = state_reg;
                req_next   = req_reg;
                dout_next  = dout_reg;
                done_next  = 1'b0;
                drop_next  = 1'b0;
                err_next   = err_reg;
                cnt_next   = cnt_reg;

                case (state_reg)
                    IDLE: begin
                        if (rise) begin
                            state_next = WAIT_ACK;
                            dout_next  = bus.d_in[gi*P_D_BITWIDTH +: P_D_BITWIDTH];
                            req_next   = P_PHASE4 ? 1'b1 : ~req_reg;
                            cnt_next   = '0;
                        end
                    end
                    WAIT_ACK: begin
                        drop_next = rise;
                        if (P_PHASE4 && ack_s) begin
                            state_next = WAIT_REL;
                            req_next   = 1'b0;
                            cnt_next   = '0;
                        end else if (!P_PHASE4 && (ack_s == req_reg)) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else if (timeout_hit) begin
                            state_next = ERROR;
                            err_next   = 1'b1;
                            req_next   = P_PHASE4 ? 1'b0 : req_reg;
                        end else if (P_TIMEOUT > 0) begin
                            cnt_next = cnt_inc;
                        end
                    end
                    WAIT_REL: begin
                        drop_next = rise;
                        if (!ack_s) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else if (timeout_hit) begin
                            state_next = ERROR;
                            err_next   = 1'b1;
                            req_next   = 1'b0;
                        end else if (P_TIMEOUT > 0) begin
                            cnt_next = cnt_inc;
                        end
                    end
                    ERROR: begin
                        drop_next = rise;
                        if (bus.clr_err[gi] && quiet) begin
                            state_next = IDLE;
                            err_next   = 1'b0;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end

            assign bus.req[gi]                                  = req_reg;
            assign bus.d_out[gi*P_D_BITWIDTH +: P_D_BITWIDTH]   = dout_reg;
            assign bus.busy[gi]                                 = busy_reg;
            assign bus.done[gi]                                 = done_reg;
            assign bus.drop[gi]                                 = drop_reg;
            assign bus.err[gi]                                  = err_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_handshake_src.sv
// Bench for sync_handshake_src: a 4-phase instance with a 16-cycle watchdog and
// a 2-phase instance without one. Directed stimulus pushes the expected
// DONE/DROP/ERR events per channel; a monitor pops and compares them whenever
// the DUT pulses one of those outputs. Timing details are checked inline.
module tb_sync_handshake_src;
    localparam int W  = 8;
    localparam int CH = 4;

    localparam int K_DONE = 0;
    localparam int K_DROP = 1;
    localparam int K_ERR  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_handshake_src_if #(.P_D_BITWIDTH(W), .P_CH(CH)) if4 ();
    sync_handshake_src_if #(.P_D_BITWIDTH(W), .P_CH(CH)) if2 ();

    sync_handshake_src #(
        .P_D_BITWIDTH(W), .P_CH(CH), .FF_DEPTH(2), .P_PHASE4(1'b1), .P_TIMEOUT(16)
    ) u4 (
        .clk(clk), .rst(rst), .bus(if4.master)
    );

    sync_handshake_src #(
        .P_D_BITWIDTH(W), .P_CH(CH), .FF_DEPTH(2), .P_PHASE4(1'b0), .P_TIMEOUT(0)
    ) u2 (
        .clk(clk), .rst(rst), .bus(if2.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp4 [CH][$];
    int exp2 [CH][$];

    function automatic int b(input logic [CH-1:0] v, input int c);
        return int'(v[c]);
    endfunction

    function automatic int dout4(input int c);
        return int'(if4.d_out[c*W +: W]);
    endfunction

    function automatic int dout2(input int c);
        return int'(if2.d_out[c*W +: W]);
    endfunction

    function automatic int ev(input int kind, input int data);
        return kind * 256 + data;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic sb_pop(input int dut, input int c, input int got);
        int want;
        if (dut == 0) begin
            if (exp4[c].size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_u4_ch%0d: unexpected event %0h", c, got);
                return;
            end
            want = exp4[c].pop_front();
        end else begin
            if (exp2[c].size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_u2_ch%0d: unexpected event %0h", c, got);
                return;
            end
            want = exp2[c].pop_front();
        end
        check($sformatf("sb_u%0d_ch%0d", (dut == 0) ? 4 : 2, c), got, want);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Well-behaved 4-phase peer for one channel of the 4-phase instance.
    task automatic peer4(input int c);
        int k;
        k = 0;
        while (if4.req[c] !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check($sformatf("peer_req_hi_ch%0d", c), b(if4.req, c), 1);
        if4.ack[c] = 1'b1;
        k = 0;
        while (if4.req[c] !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        check($sformatf("peer_req_lo_ch%0d", c), b(if4.req, c), 0);
        if4.ack[c] = 1'b0;
        k = 0;
        while (if4.busy[c] !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        check($sformatf("peer_idle_ch%0d", c), b(if4.busy, c), 0);
    endtask

    // Monitor: every DONE/DROP pulse and every ERR rise must match the scoreboard.
    initial begin : monitor
        logic [CH-1:0] err4_prev;
        logic [CH-1:0] err2_prev;
        err4_prev = '0;
        err2_prev = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (if4.done[c]) sb_pop(0, c, ev(K_DONE, dout4(c)));
                if (if4.drop[c]) sb_pop(0, c, ev(K_DROP, dout4(c)));
                if (if4.err[c] && !err4_prev[c]) sb_pop(0, c, ev(K_ERR, dout4(c)));
                if (if2.done[c]) sb_pop(1, c, ev(K_DONE, dout2(c)));
                if (if2.drop[c]) sb_pop(1, c, ev(K_DROP, dout2(c)));
                if (if2.err[c] && !err2_prev[c]) sb_pop(1, c, ev(K_ERR, dout2(c)));
            end
            err4_prev = if4.err;
            err2_prev = if2.err;
        end
    end

    initial begin : stim
        rst = 1'b1;
        if4.send_en = '0; if4.d_in = '0; if4.ack = '0; if4.clr_err = '0;
        if2.send_en = '0; if2.d_in = '0; if2.ack = '0; if2.clr_err = '0;
        tick(2);
        check("rst_req4",  int'(if4.req),  0);
        check("rst_busy4", int'(if4.busy), 0);
        check("rst_err4",  int'(if4.err),  0);
        check("rst_dout4", int'(if4.d_out), 0);
        check("rst_done_drop4", int'({if4.done, if4.drop}), 0);
        check("rst_req2",  int'(if2.req),  0);
        check("rst_dout2", int'(if2.d_out), 0);
        rst = 1'b0;
        tick(1);

        // 1) 4-phase basic transfer on channel 0
        if4.d_in[7:0] = 8'hA5; if4.send_en[0] = 1'b1;
        exp4[0].push_back(ev(K_DONE, 8'hA5));
        tick(1);
        check("t1_dout", dout4(0), 8'hA5);
        check("t1_req",  b(if4.req, 0), 1);
        check("t1_busy", b(if4.busy, 0), 1);
        if4.send_en[0] = 1'b0;
        tick(2);
        if4.ack[0] = 1'b1;
        tick(2);
        check("t1_req_hold", b(if4.req, 0), 1);
        tick(1);
        check("t1_req_fall", b(if4.req, 0), 0);
        check("t1_busy_rel", b(if4.busy, 0), 1);
        if4.ack[0] = 1'b0;
        tick(2);
        check("t1_done_early", b(if4.done, 0), 0);
        tick(1);
        check("t1_done", b(if4.done, 0), 1);
        check("t1_idle", b(if4.busy, 0), 0);
        tick(1);
        check("t1_done_1cyc", b(if4.done, 0), 0);

        // 2) 2-phase: 8'h11 then 8'h22, second edge lands in the DONE cycle
        if2.d_in[7:0] = 8'h11; if2.send_en[0] = 1'b1;
        exp2[0].push_back(ev(K_DONE, 8'h11));
        tick(1);
        check("t2_req_a",  b(if2.req, 0), 1);
        check("t2_dout_a", dout2(0), 8'h11);
        if2.send_en[0] = 1'b0;
        if2.ack[0] = 1'b1;
        tick(2);
        check("t2_busy_a", b(if2.busy, 0), 1);
        tick(1);
        check("t2_done_a", b(if2.done, 0), 1);
        check("t2_req_a2", b(if2.req, 0), 1);
        if2.d_in[7:0] = 8'h22; if2.send_en[0] = 1'b1;
        exp2[0].push_back(ev(K_DONE, 8'h22));
        tick(1);
        check("t2_req_b",  b(if2.req, 0), 0);
        check("t2_dout_b", dout2(0), 8'h22);
        check("t2_busy_b", b(if2.busy, 0), 1);
        if2.send_en[0] = 1'b0;
        if2.ack[0] = 1'b0;
        tick(3);
        check("t2_done_b", b(if2.done, 0), 1);
        check("t2_req_b2", b(if2.req, 0), 0);
        tick(1);

        // 3) drop on ch1 while waiting, ch2 transfer in parallel
        if4.d_in[15:8] = 8'h3C; if4.d_in[23:16] = 8'h5A;
        if4.send_en[1] = 1'b1; if4.send_en[2] = 1'b1;
        exp4[2].push_back(ev(K_DONE, 8'h5A));
        tick(1);
        check("t3_dout1", dout4(1), 8'h3C);
        if4.send_en[1] = 1'b0;
        tick(1);
        if4.d_in[15:8] = 8'hFF; if4.send_en[1] = 1'b1;
        exp4[1].push_back(ev(K_DROP, 8'h3C));
        exp4[1].push_back(ev(K_DONE, 8'h3C));
        tick(1);
        check("t3_drop1", b(if4.drop, 1), 1);
        check("t3_dout1_keep", dout4(1), 8'h3C);
        if4.send_en[1] = 1'b0;
        tick(1);
        check("t3_drop1_1cyc", b(if4.drop, 1), 0);
        fork
            peer4(1);
            peer4(2);
        join
        check("t3_dout1_end", dout4(1), 8'h3C);
        check("t3_dout2_end", dout4(2), 8'h5A);
        tick(2);
        check("t3_held_no_rerun_busy", b(if4.busy, 2), 0);
        check("t3_held_no_rerun_req",  b(if4.req, 2), 0);
        if4.send_en[2] = 1'b0;
        tick(1);

        // 4) watchdog in WAIT_ACK, drop in ERROR, clear
        if4.d_in[7:0] = 8'h77; if4.send_en[0] = 1'b1;
        exp4[0].push_back(ev(K_ERR, 8'h77));
        tick(1);
        check("t4_busy", b(if4.busy, 0), 1);
        if4.send_en[0] = 1'b0;
        tick(15);
        check("t4_err_early", b(if4.err, 0), 0);
        check("t4_req_early", b(if4.req, 0), 1);
        tick(1);
        check("t4_err", b(if4.err, 0), 1);
        check("t4_req_forced", b(if4.req, 0), 0);
        if4.send_en[0] = 1'b1;
        exp4[0].push_back(ev(K_DROP, 8'h77));
        tick(1);
        check("t4_drop_err", b(if4.drop, 0), 1);
        if4.send_en[0] = 1'b0;
        if4.clr_err[0] = 1'b1;
        tick(1);
        check("t4_err_clr", b(if4.err, 0), 0);
        check("t4_idle", b(if4.busy, 0), 0);
        check("t4_no_done", b(if4.done, 0), 0);
        if4.clr_err[0] = 1'b0;
        tick(1);

        // 5) watchdog in WAIT_REL with ACK stuck high; clear waits for ACK low
        if4.d_in[7:0] = 8'h99; if4.send_en[0] = 1'b1;
        exp4[0].push_back(ev(K_ERR, 8'h99));
        tick(1);
        check("t5_req", b(if4.req, 0), 1);
        if4.send_en[0] = 1'b0;
        if4.ack[0] = 1'b1;
        tick(3);
        check("t5_req_fall", b(if4.req, 0), 0);
        check("t5_busy", b(if4.busy, 0), 1);
        tick(15);
        check("t5_err_early", b(if4.err, 0), 0);
        tick(1);
        check("t5_err", b(if4.err, 0), 1);
        if4.clr_err[0] = 1'b1;
        tick(3);
        check("t5_clr_ignored", b(if4.err, 0), 1);
        check("t5_still_busy", b(if4.busy, 0), 1);
        if4.ack[0] = 1'b0;
        tick(2);
        check("t5_err_sync", b(if4.err, 0), 1);
        tick(1);
        check("t5_err_clr", b(if4.err, 0), 0);
        check("t5_idle", b(if4.busy, 0), 0);
        if4.clr_err[0] = 1'b0;
        tick(1);

        // 6) asynchronous reset mid-transfer, then a clean transfer
        if4.d_in[31:24] = 8'hC3; if4.send_en[3] = 1'b1;
        tick(1);
        check("t6_req", b(if4.req, 3), 1);
        check("t6_busy", b(if4.busy, 3), 1);
        check("t6_dout", dout4(3), 8'hC3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_req",  int'(if4.req), 0);
        check("t6_rst_busy", int'(if4.busy), 0);
        check("t6_rst_dout", int'(if4.d_out), 0);
        check("t6_rst_dout2", int'(if2.d_out), 0);
        if4.send_en[3] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        if4.d_in[31:24] = 8'hE7; if4.send_en[3] = 1'b1;
        exp4[3].push_back(ev(K_DONE, 8'hE7));
        tick(1);
        check("t6_new_dout", dout4(3), 8'hE7);
        if4.send_en[3] = 1'b0;
        peer4(3);
        tick(4);

        for (int c = 0; c < CH; c++) begin
            check($sformatf("sb_left_u4_ch%0d", c), exp4[c].size(), 0);
            check($sformatf("sb_left_u2_ch%0d", c), exp2[c].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL tb_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end
endmodule
